// File: rtl/icache_sa.sv
// Set-associative instruction cache with zero-latency hits, burst refill over a
// 64-bit memory bus, per-set round-robin replacement and full invalidation.
package icache_sa_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_t;

    // size is log2(bytes per beat); len is the beat count of the burst
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  len;
        burst_t      burst;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp,
    input  logic       inv_req,
    output logic       inv_done
);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = 3 + WORD_W;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, INVAL} state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  fill_idx_reg;
    logic [TAG_W-1:0]  fill_tag_reg;
    logic [WAY_W-1:0]  victim_reg;
    logic [WORD_W-1:0] beat_reg;
    logic              inv_pend_reg;

    logic [SETS-1:0]   valid_reg [WAYS];
    logic [WAY_W-1:0]  vptr_reg  [SETS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;
    logic [WAYS-1:0]   way_hit;
    logic [63:0]       way_word [WAYS];
    logic              hit;
    logic [63:0]       hit_word;
    logic              fill_we;
    logic              fill_last;
    logic              miss_start;
    logic              unused_addr_bits;

    assign req_idx   = ireq.addr[OFF_W +: IDX_W];
    assign req_tag   = ireq.addr[31 -: TAG_W];
    assign req_word  = ireq.addr[3 +: WORD_W];
    assign unused_addr_bits = ^ireq.addr[1:0];

    assign fill_we    = (state_reg == FETCH) && cresp.ready;
    assign fill_last  = fill_we && cresp.last;
    assign miss_start = (state_reg == IDLE) && !inv_req && ireq.valid && !hit;

    // Tag and data storage per way; read asynchronously so a hit answers in the request cycle
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [63:0]      data_mem [SETS*LINE_WORDS];
            logic [TAG_W-1:0] tag_mem  [SETS];

            always_ff @(posedge clk) begin
                if (fill_we && (victim_reg == WAY_W'(gi))) begin
                    data_mem[{fill_idx_reg, beat_reg}] <= cresp.data;
                    if (cresp.last) begin
                        tag_mem[fill_idx_reg] <= fill_tag_reg;
                    end
                end
            end

            assign way_hit[gi]  = valid_reg[gi][req_idx] && (tag_mem[req_idx] == req_tag);
            assign way_word[gi] = data_mem[{req_idx, req_word}];
        end
    endgenerate

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit      = 1'b1;
                hit_word = way_word[w];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            fill_idx_reg <= '0;
            fill_tag_reg <= '0;
            victim_reg   <= '0;
            beat_reg     <= '0;
            inv_pend_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (miss_start) begin
                fill_idx_reg <= req_idx;
                fill_tag_reg <= req_tag;
                victim_reg   <= vptr_reg[req_idx];
                beat_reg     <= '0;
            end else if (fill_we) begin
                beat_reg <= cresp.last ? '0 : beat_reg + 1'b1;
            end
            if (state_reg != FETCH) begin
                inv_pend_reg <= 1'b0;
            end else if (inv_req) begin
                inv_pend_reg <= 1'b1;
            end
        end
    end

    // The victim's valid bit drops as the refill starts, so an interrupted fill never exposes a mixed line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_reg[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                vptr_reg[s] <= '0;
            end
        end else if (state_reg == INVAL) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_reg[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                vptr_reg[s] <= '0;
            end
        end else begin
            if (miss_start) begin
                valid_reg[vptr_reg[req_idx]][req_idx] <= 1'b0;
            end
            if (fill_last) begin
                valid_reg[victim_reg][fill_idx_reg] <= 1'b1;
                vptr_reg[fill_idx_reg] <= (WAYS == 1) ? '0 : vptr_reg[fill_idx_reg] + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        iresp      = '0;
        creq       = '0;
        inv_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (inv_req) begin
                    state_next = INVAL;
                end else if (ireq.valid) begin
                    if (hit) begin
                        iresp.addr_ok = 1'b1;
                        iresp.data_ok = 1'b1;
                        iresp.data    = ireq.addr[2] ? hit_word[63:32] : hit_word[31:0];
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                creq.valid    = 1'b1;
                creq.is_write = 1'b0;
                creq.size     = 3'd3;
                creq.addr     = {fill_tag_reg, fill_idx_reg, {OFF_W{1'b0}}};
                creq.len      = 8'(LINE_WORDS);
                creq.burst    = BURST_INCR;
                if (fill_last) begin
                    state_next = (inv_pend_reg || inv_req) ? INVAL : IDLE;
                end
            end
            INVAL: begin
                inv_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: vector table of fetches plus hand sequences for
// invalidation, reset mid-refill and stalled refill.
module tb_icache_sa;
    import icache_sa_pkg::*;

    logic       clk;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic       inv_req;
    logic       inv_done;

    int n_checks = 0;
    int n_fail   = 0;

    icache_sa dut (
        .clk      (clk),
        .reset    (reset),
        .ireq     (ireq),
        .iresp    (iresp),
        .creq     (creq),
        .cresp    (cresp),
        .inv_req  (inv_req),
        .inv_done (inv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents model: one 64-bit word per 8-byte address
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [31:0] a8;
        a8 = {a[31:3], 3'b000};
        return {~a8, a8 ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        logic [63:0] w;
        w = mem_word(a);
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    function automatic cbus_req_t exp_creq(input logic [31:0] a);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = 1'b0;
        r.size     = 3'd3;
        r.addr     = {a[31:5], 5'b0};
        r.len      = 8'd4;
        r.burst    = BURST_INCR;
        return r;
    endfunction

    // Drives the four refill beats; returns on the negedge after the last beat
    task automatic fill(input logic [31:0] a, input int stall, input int inv_beat, input bit drop);
        logic [31:0] line;
        line = {a[31:5], 5'b0};
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                cresp   = '0;
                inv_req = 1'b0;
                #1;
                chk("creq_stall", creq, exp_creq(a));
            end
            @(negedge clk);
            cresp.ready = 1'b1;
            cresp.last  = (b == 3);
            cresp.data  = mem_word(line + 32'(b * 8));
            inv_req     = (b == inv_beat);
            if (drop) ireq.valid = 1'b0;
            #1;
            chk("creq_beat", creq, exp_creq(a));
            chk("resp_in_fetch", {iresp.addr_ok, iresp.data_ok}, 2'b00);
        end
        @(negedge clk);
        cresp      = '0;
        inv_req    = 1'b0;
        ireq.valid = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] a, input bit exp_hit, input int stall = 0,
                         input int inv_beat = -1, input bit drop = 1'b0);
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        cresp      = '0;
        #1;
        chk("hit_flags", {iresp.addr_ok, iresp.data_ok}, exp_hit ? 2'b11 : 2'b00);
        chk("idle_creq_valid", creq.valid, 1'b0);
        if (exp_hit) begin
            chk("hit_data", iresp.data, exp_data(a));
        end else begin
            fill(a, stall, inv_beat, drop);
            #1;
            if (inv_beat >= 0) begin
                chk("inv_done_after_fill", inv_done, 1'b1);
                chk("no_hit_in_inval", iresp.addr_ok, 1'b0);
            end else begin
                chk("post_fill_flags", {iresp.addr_ok, iresp.data_ok}, 2'b11);
                chk("post_fill_data", iresp.data, exp_data(a));
            end
        end
        $display("fetch %08h expect_hit=%0d resp=%0b%0b data=%08h", a, exp_hit,
                 iresp.addr_ok, iresp.data_ok, iresp.data);
        ireq.valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          hit;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h8000_0000, 1'b0};
        vecs[1]  = '{32'h8000_001C, 1'b1};
        vecs[2]  = '{32'h8000_0008, 1'b1};
        vecs[3]  = '{32'h8000_0200, 1'b0};
        vecs[4]  = '{32'h8000_0204, 1'b1};
        vecs[5]  = '{32'h8000_0400, 1'b0};
        vecs[6]  = '{32'h8000_0200, 1'b1};
        vecs[7]  = '{32'h8000_0000, 1'b0};
        vecs[8]  = '{32'h8000_0400, 1'b1};
        vecs[9]  = '{32'h8000_0200, 1'b0};
        vecs[10] = '{32'h8000_0020, 1'b0};
        vecs[11] = '{32'h8000_0024, 1'b1};

        reset   = 1'b1;
        ireq    = '0;
        cresp   = '0;
        inv_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_iresp", iresp, '0);
        chk("reset_creq_valid", creq.valid, 1'b0);
        chk("reset_inv_done", inv_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            fetch(vecs[i].addr, vecs[i].hit);
        end

        // Invalidate from IDLE takes priority over a hitting request
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = 32'h8000_0020;
        inv_req    = 1'b1;
        #1;
        chk("inv_priority", {iresp.addr_ok, iresp.data_ok}, 2'b00);
        chk("inv_done_early", inv_done, 1'b0);
        @(negedge clk);
        inv_req    = 1'b0;
        ireq.valid = 1'b0;
        #1;
        chk("inv_done_pulse", inv_done, 1'b1);
        @(negedge clk);
        #1;
        chk("inv_done_single", inv_done, 1'b0);
        $display("invalidate from idle done");
        fetch(32'h8000_0000, 1'b0);
        fetch(32'h8000_0024, 1'b0);

        // Invalidate during the second beat of a refill
        fetch(32'h8000_0040, 1'b0, 0, 1);
        @(negedge clk);
        #1;
        chk("inv_done_clears", inv_done, 1'b0);
        fetch(32'h8000_0040, 1'b0);

        // Back-to-back inv_req is absorbed by the running invalidation
        @(negedge clk);
        inv_req = 1'b1;
        @(negedge clk);
        #1;
        chk("absorb_inv_done", inv_done, 1'b1);
        @(negedge clk);
        inv_req = 1'b0;
        #1;
        chk("absorb_no_second", inv_done, 1'b0);
        $display("absorbed inv_req");

        // Reset after two of four beats
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = 32'h8000_0060;
        #1;
        chk("rst_miss", iresp.addr_ok, 1'b0);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            cresp.ready = 1'b1;
            cresp.last  = 1'b0;
            cresp.data  = 64'hDEAD_BEEF_0000_0000 | 64'(b);
        end
        @(negedge clk);
        cresp = '0;
        #1;
        chk("pre_reset_creq", creq, exp_creq(32'h8000_0060));
        reset = 1'b1;
        #1;
        chk("async_reset_creq", creq.valid, 1'b0);
        @(negedge clk);
        reset      = 1'b0;
        ireq.valid = 1'b0;
        $display("reset mid-refill applied");
        fetch(32'h8000_0060, 1'b0);
        fetch(32'h8000_0068, 1'b1);
        fetch(32'h8000_0074, 1'b1);

        // Stalled refill with ireq.valid dropped during the burst
        fetch(32'h8000_0080, 1'b0, 3, -1, 1'b1);
        fetch(32'h8000_0084, 1'b1);
        fetch(32'h8000_0088, 1'b1);
        fetch(32'h8000_0090, 1'b1);
        fetch(32'h8000_009C, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_sa.md
ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 Parameter WAYS, default 2, associativity; power of two, 1..8.
REQ-002 Parameter SETS, default 16, sets per way; power of two, 2..256.
REQ-003 Parameter LINE_WORDS, default 4, 64-bit words per line; one of 2, 4, 8, 16.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ireq  input  ibus_req_t  fetch request (valid, addr); addr held stable until addr_ok.
REQ-007 iresp  output  ibus_resp_t  fetch response (addr_ok, data_ok, 32-bit data).
REQ-008 creq  output  cbus_req_t  refill burst request to memory bus.
REQ-009 cresp  input  cbus_resp_t  memory bus response (ready, last, 64-bit data).
REQ-010 inv_req  input  1  single-cycle pulse requesting full invalidation (fence.i).
REQ-011 inv_done  output  1  single-cycle pulse when invalidation completes.

Function
REQ-012 Address split SHALL be offset = addr[3+log2(LINE_WORDS)-1:0], index = next log2(SETS) bits, tag = remaining upper bits of addr.
REQ-013 Storage per set/way SHALL be valid bit, tag, LINE_WORDS data words; plus one per-set round-robin victim pointer of log2(WAYS) bits (zero width when WAYS=1).
REQ-014 FSM states SHALL be IDLE, FETCH, INVAL.
REQ-015 In IDLE with ireq.valid and a tag match on a valid way, addr_ok and data_ok SHALL both be 1 combinationally in the same cycle (zero-latency hit).
REQ-016 Hit data SHALL be the selected 64-bit word's upper half when addr[2]=1, else lower half; addr[1:0] non-zero gives undefined data.
REQ-017 In IDLE with ireq.valid and no hit, addr_ok=data_ok=0 and FSM SHALL enter FETCH next cycle, latching line-aligned address, index, tag and victim way = victim pointer of that set.
REQ-018 In FETCH, creq SHALL be valid=1, is_write=0, size=8 bytes, addr=line-aligned address, len=LINE_WORDS beats, burst=INCR, strobe=0, data=0; held constant until last beat.
REQ-019 Each cycle with cresp.ready=1 SHALL write cresp.data into victim way word at beat counter, then increment counter; ready=0 cycles SHALL stall without state change.
REQ-020 On beat with cresp.ready=1 and cresp.last=1: write tag, set valid, advance set's victim pointer modulo WAYS, return to IDLE; the pending fetch SHALL then hit on the following cycle.
REQ-021 While in FETCH or INVAL, iresp.addr_ok and data_ok SHALL be 0.
REQ-022 ireq.valid dropping during FETCH SHALL NOT abort the refill.
REQ-023 inv_req in IDLE SHALL take priority over ireq (no hit reported that cycle) and enter INVAL; INVAL lasts one cycle, clears all valid bits and victim pointers, pulses inv_done, returns to IDLE.
REQ-024 inv_req arriving in FETCH SHALL be latched as pending; INVAL entered right after the last beat instead of IDLE, so the just-filled line is also invalidated.
REQ-025 inv_req arriving in INVAL SHALL be absorbed by the current invalidation.
REQ-026 Outside FETCH, creq.valid SHALL be 0.

Reset
REQ-027 Reset assertion SHALL immediately force state IDLE, creq.valid=0, iresp fields 0, inv_done=0, beat counter 0, pending-invalidate 0, all valid bits and victim pointers 0; data/tag arrays need no reset.
REQ-028 Reset mid-refill SHALL discard the partial line; no line becomes valid.

Verification (defaults: 32-byte lines, index addr[8:5])
REQ-029 Cold fetch 0x8000_0000, cresp beats D0..D3 -> creq addr 0x8000_0000, 4 beats; next cycle data=D0[31:0] with addr_ok=data_ok=1; fetch 0x8000_001C hits same cycle, data=D3[63:32], no creq.
REQ-030 Fill 0x8000_0000 then 0x8000_0200 (both index 0), then 0x8000_0400 -> third evicts way 0; refetch 0x8000_0200 hits, 0x8000_0000 misses.
REQ-031 After REQ-029 fill, inv_req pulse -> inv_done exactly one cycle later; refetch 0x8000_0000 issues new burst.
REQ-032 inv_req during second beat of refill -> inv_done one cycle after last beat; subsequent fetch of that line misses.
REQ-033 Reset asserted after 2 of 4 beats -> creq.valid=0 asynchronously; after release, fetch of same address issues full 4-beat burst.
REQ-034 cresp.ready low 3 cycles between each beat -> line contents identical to zero-stall fill, creq unchanged throughout.
